// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module  : fifo_arb_pkg
// Brief   : Shared types and helpers for the FIFO write-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int beat_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    function automatic int wrap_idx(input int idx, input int num);
        return idx % num;
    endfunction

    function automatic logic onehot_bit(input int idx, input int pos);
        return (idx == pos);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker; searches upward from i_rr_last+1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_last,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_valid
);

    logic [IDX_W-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = IDX_W'(wrap_idx(int'(i_rr_last) + k, NUM_REQ));
            if (i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ============================================================================
// Module  : fifo_write_arbiter
// Brief   : Round-robin burst arbiter for the async FIFO write port.
//           Define FIFO_ARB_PRIO_EN to give requester 0 priority in arbitration.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wen,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = beat_cnt_width(MAX_BURST);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [IDX_W-1:0]   r_rr_last;
    logic [IDX_W-1:0]   w_rr_last_nxt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_beat_cnt_nxt;

    logic [IDX_W-1:0]   w_rr_winner;
    logic               w_rr_valid;
    logic [IDX_W-1:0]   w_winner;
    logic               w_req_g;
    logic               w_accept;
    logic               w_burst_end;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req     (req),
        .i_rr_last (r_rr_last),
        .o_winner  (w_rr_winner),
        .o_valid   (w_rr_valid)
    );

`ifdef FIFO_ARB_PRIO_EN
    assign w_winner = req[0] ? '0 : w_rr_winner;
`else
    assign w_winner = w_rr_winner;
`endif

    // While in BURST, r_rr_last is the index of the granted requester.
    assign w_req_g     = req[r_rr_last];
    assign w_accept    = w_req_g & ~fifo_full;
    assign w_burst_end = ~w_req_g
                       | (w_accept & (req_last[r_rr_last]
                                      | (r_beat_cnt == CNT_W'(MAX_BURST - 1))));

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state    <= ARB;
            r_gnt      <= '0;
            r_rr_last  <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rr_last  <= w_rr_last_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_rr_last_nxt  = r_rr_last;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ARB: begin
                w_gnt_nxt      = '0;
                w_beat_cnt_nxt = '0;
                if (w_rr_valid) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        w_gnt_nxt[i] = onehot_bit(int'(w_winner), i);
                    end
                    w_rr_last_nxt = w_winner;
                    w_state_nxt   = BURST;
                end
            end
            BURST: begin
                if (w_burst_end) begin
                    w_state_nxt    = ARB;
                    w_gnt_nxt      = '0;
                    w_beat_cnt_nxt = '0;
                end else if (w_accept) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = ARB;
                w_gnt_nxt      = '0;
                w_beat_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        fifo_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) begin
                fifo_wdata = fifo_wdata | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign gnt      = r_gnt;
    assign fifo_wen = (|(r_gnt & req)) & ~fifo_full;
    assign busy     = (r_state == BURST);

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
// Module  : tb_fifo_write_arbiter
// Brief   : Self-checking bench with cycle model and write-data scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            wclk = 1'b0;
    logic            wrst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic            fifo_full;
    logic [N-1:0]    gnt;
    logic            fifo_wen;
    logic [DW-1:0]   fifo_wdata;
    logic            busy;

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) u_dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .req        (req),
        .req_last   (req_last),
        .req_data   (req_data),
        .fifo_full  (fifo_full),
        .gnt        (gnt),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .busy       (busy)
    );

    always #5 wclk = ~wclk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_q[$];
    int            seq[N];

    // Reference model state
    bit m_busy;
    int m_g;
    int m_last;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_busy = 1'b0;
        m_g    = 0;
        m_last = N - 1;
        m_cnt  = 0;
    endfunction

    function automatic void m_clock();
        bit acc;
        if (wrst) begin
            m_reset();
        end else if (!m_busy) begin
            for (int k = N; k >= 1; k--) begin
                if (req[(m_last + k) % N]) begin
                    m_busy = 1'b1;
                    m_g    = (m_last + k) % N;
                end
            end
`ifdef FIFO_ARB_PRIO_EN
            if (req[0]) begin
                m_busy = 1'b1;
                m_g    = 0;
            end
`endif
            if (m_busy) begin
                m_last = m_g;
                m_cnt  = 0;
            end
        end else begin
            acc = req[m_g] && !fifo_full;
            if (acc) seq[m_g]++;
            if (!req[m_g] || (acc && (req_last[m_g] || m_cnt == MB - 1))) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else if (acc) begin
                m_cnt++;
            end
        end
    endfunction

    task automatic tick();
        logic [N-1:0]  e_gnt;
        logic          e_wen;
        logic [DW-1:0] e_data;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = DW'((i << 6) | (seq[i] & 63));
        end
        @(negedge wclk);
        if (wrst) m_reset();
        e_gnt  = m_busy ? N'(1 << m_g) : '0;
        e_wen  = m_busy && req[m_g] && !fifo_full;
        e_data = m_busy ? req_data[m_g*DW +: DW] : '0;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("fifo_wen", 32'(fifo_wen), 32'(e_wen));
        chk("fifo_wdata", 32'(fifo_wdata), 32'(e_data));
        if (e_wen) exp_q.push_back(e_data);
        if (fifo_wen === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_write", 32'(fifo_wdata), 32'hFFFF_FFFF);
            else                   chk("wr_data", 32'(fifo_wdata), 32'(exp_q.pop_front()));
        end
        @(posedge wclk);
        m_clock();
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 0;
        m_reset();
        wrst      = 1'b1;
        req       = 4'b1111;
        req_last  = '0;
        fifo_full = 1'b0;
        req_data  = '0;

        // Reset held with all requesting, then round-robin fairness
        repeat (3) tick();
        wrst = 1'b0;
        repeat (26) tick();
        req = '0;
        repeat (3) tick();

        // Early end-of-burst on second beat of requester 2
        req = 4'b0100;
        repeat (2) tick();
        req_last = 4'b0100;
        tick();
        req_last = '0;
        req      = '0;
        repeat (2) tick();

        // Full stall mid-burst
        req = 4'b0010;
        repeat (2) tick();
        fifo_full = 1'b1;
        repeat (3) tick();
        fifo_full = 1'b0;
        repeat (6) tick();
        req = '0;
        repeat (2) tick();

        // Withdraw mid-burst, then reset pulse mid-burst
        req = 4'b0010;
        repeat (3) tick();
        req = '0;
        repeat (2) tick();
        req = 4'b1000;
        repeat (3) tick();
        wrst = 1'b1;
        tick();
        wrst = 1'b0;
        req  = '0;
        repeat (2) tick();

        // Requester 0 repeated win (priority build) and no preemption of a burst
        req = 4'b0001;
        repeat (3) tick();
        req = '0;
        tick();
        req = 4'b0011;
        repeat (3) tick();
        req = '0;
        repeat (2) tick();
        req = 4'b0010;
        repeat (2) tick();
        req = 4'b0011;
        repeat (4) tick();
        req = '0;
        repeat (2) tick();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            req       = N'($urandom);
            req_last  = N'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            wrst      = ($urandom_range(0, 99) == 0);
            tick();
        end
        wrst      = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
